// File: rtl/register_write_scheduler_if.sv
// Register-file write port bundle: EU and MEM request channels plus the
// scheduled write port and pending/idle status seen by operand fetch.
interface register_write_scheduler_if #(
  parameter int NUM_REGISTERS = 8
);
  localparam int W = $clog2(NUM_REGISTERS);

  logic                     eu_valid;
  logic                     eu_ready;
  logic                     eu_dual;
  logic [W-1:0]             eu_id0;
  logic [W-1:0]             eu_id1;
  logic [15:0]              eu_data0;
  logic [15:0]              eu_data1;

  logic                     mem_valid;
  logic                     mem_ready;
  logic [W-1:0]             mem_id;
  logic [15:0]              mem_data;

  logic                     we;
  logic [W-1:0]             write_id;
  logic [15:0]              write_data;
  logic [NUM_REGISTERS-1:0] pending;
  logic                     idle;

  modport master (
    output eu_valid, eu_dual, eu_id0, eu_id1, eu_data0, eu_data1,
    output mem_valid, mem_id, mem_data,
    input  eu_ready, mem_ready,
    input  we, write_id, write_data, pending, idle
  );

  modport slave (
    input  eu_valid, eu_dual, eu_id0, eu_id1, eu_data0, eu_data1,
    input  mem_valid, mem_id, mem_data,
    output eu_ready, mem_ready,
    output we, write_id, write_data, pending, idle
  );
endinterface

// File: rtl/register_write_scheduler.sv
// Arbitrates EU and MEM writes onto the single register-file write port,
// splitting EU dual writes into two consecutive port writes.
module register_write_scheduler #(
  parameter int NUM_REGISTERS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  register_write_scheduler_if.slave     bus
);
  localparam int W = $clog2(NUM_REGISTERS);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    PRIO_EU  = 1'b0,
    PRIO_MEM = 1'b1
  } prio_t;

  state_t                   state_r;
  prio_t                    prio_r;
  logic                     we_r;
  logic [W-1:0]             write_id_r;
  logic [15:0]              write_data_r;
  logic [W-1:0]             hold_id_r;
  logic [15:0]              hold_data_r;

  logic                     eu_ready_s;
  logic                     mem_ready_s;
  logic                     eu_accept_s;
  logic                     mem_accept_s;
  logic [NUM_REGISTERS-1:0] pending_s;

  function automatic logic [NUM_REGISTERS-1:0] onehot(input logic [W-1:0] id);
    logic [NUM_REGISTERS-1:0] v;
    v     = {NUM_REGISTERS{1'b0}};
    v[id] = 1'b1;
    return v;
  endfunction

  // Handshake readies: the prio flag only matters when both sides request.
  always_comb begin
    eu_ready_s  = 1'b0;
    mem_ready_s = 1'b0;
    if (reset && (state_r == S_IDLE)) begin
      eu_ready_s  = !bus.mem_valid || (prio_r == PRIO_EU);
      mem_ready_s = !bus.eu_valid  || (prio_r == PRIO_MEM);
    end else begin
      eu_ready_s  = 1'b0;
      mem_ready_s = 1'b0;
    end
  end

  assign eu_accept_s  = bus.eu_valid  && eu_ready_s;
  assign mem_accept_s = bus.mem_valid && mem_ready_s;

  // Scheduler FSM and registered write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      prio_r       <= PRIO_EU;
      we_r         <= 1'b0;
      write_id_r   <= {W{1'b0}};
      write_data_r <= 16'h0000;
      hold_id_r    <= {W{1'b0}};
      hold_data_r  <= 16'h0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (eu_accept_s) begin
            we_r         <= 1'b1;
            write_id_r   <= bus.eu_id0;
            write_data_r <= bus.eu_data0;
            prio_r       <= PRIO_MEM;
            if (bus.eu_dual) begin
              hold_id_r   <= bus.eu_id1;
              hold_data_r <= bus.eu_data1;
              state_r     <= S_SECOND;
            end else begin
              state_r     <= S_IDLE;
            end
          end else if (mem_accept_s) begin
            we_r         <= 1'b1;
            write_id_r   <= bus.mem_id;
            write_data_r <= bus.mem_data;
            prio_r       <= PRIO_EU;
          end else begin
            we_r         <= 1'b0;
          end
        end
        S_SECOND: begin
          we_r         <= 1'b1;
          write_id_r   <= hold_id_r;
          write_data_r <= hold_data_r;
          state_r      <= S_IDLE;
        end
        default: begin
          we_r    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Registers still owed a write: the one on the port plus the held half.
  always_comb begin
    pending_s = {NUM_REGISTERS{1'b0}};
    if (we_r) begin
      pending_s = onehot(write_id_r);
    end else begin
      pending_s = {NUM_REGISTERS{1'b0}};
    end
    if (state_r == S_SECOND) begin
      pending_s = pending_s | onehot(hold_id_r);
    end else begin
      pending_s = pending_s;
    end
  end

  assign bus.eu_ready   = eu_ready_s;
  assign bus.mem_ready  = mem_ready_s;
  assign bus.we         = we_r;
  assign bus.write_id   = write_id_r;
  assign bus.write_data = write_data_r;
  assign bus.pending    = pending_s;
  assign bus.idle       = (state_r == S_IDLE) && !we_r;

endmodule

// File: tb/tb_register_write_scheduler.sv
// Directed bench for register_write_scheduler: a commit-queue model checked every
// cycle, plus literal expectations from the hand-worked scenarios.
module tb_register_write_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_write_scheduler_if #(.NUM_REGISTERS(8)) bus();
  register_write_scheduler #(.NUM_REGISTERS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register file fed by the port, for end-state checks.
  logic [15:0] rf [8];
  initial for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
  always @(posedge clk) if (bus.we === 1'b1) rf[bus.write_id] <= bus.write_data;

  // Model: queue of accepted-but-not-yet-driven writes; a new request is only
  // taken when that queue is empty, and the port drives one entry per edge.
  typedef struct { logic [2:0] id; logic [15:0] data; } wr_t;
  wr_t         q[$];
  bit          m_prio_mem = 1'b0;
  bit          m_we = 1'b0;
  logic [2:0]  m_wid = 3'd0;
  logic [15:0] m_wdata = 16'h0000;
  bit          started = 1'b0;

  always @(posedge clk) begin
    wr_t w;
    bit  eu_ok, mem_ok;
    eu_ok  = reset && q.size() == 0 && (!bus.mem_valid || !m_prio_mem);
    mem_ok = reset && q.size() == 0 && (!bus.eu_valid || m_prio_mem);
    if (!reset) begin
      q.delete();
      m_we = 1'b0; m_wid = 3'd0; m_wdata = 16'h0000; m_prio_mem = 1'b0;
    end else begin
      if (bus.eu_valid && eu_ok) begin
        q.push_back('{bus.eu_id0, bus.eu_data0});
        if (bus.eu_dual) q.push_back('{bus.eu_id1, bus.eu_data1});
        m_prio_mem = 1'b1;
      end else if (bus.mem_valid && mem_ok) begin
        q.push_back('{bus.mem_id, bus.mem_data});
        m_prio_mem = 1'b0;
      end
      if (q.size() > 0) begin
        w = q.pop_front();
        m_we = 1'b1; m_wid = w.id; m_wdata = w.data;
      end else begin
        m_we = 1'b0;
      end
    end
    started = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) if (started) begin
    logic [7:0] ep;
    bit e_eu, e_mem;
    ep = 8'h00;
    if (m_we) ep[m_wid] = 1'b1;
    foreach (q[i]) ep[q[i].id] = 1'b1;
    e_eu  = reset && q.size() == 0 && (!bus.mem_valid || !m_prio_mem);
    e_mem = reset && q.size() == 0 && (!bus.eu_valid || m_prio_mem);
    chk("m_eu_ready",   {15'd0, bus.eu_ready},  {15'd0, e_eu});
    chk("m_mem_ready",  {15'd0, bus.mem_ready}, {15'd0, e_mem});
    chk("m_we",         {15'd0, bus.we},        {15'd0, m_we});
    chk("m_write_id",   {13'd0, bus.write_id},  {13'd0, m_wid});
    chk("m_write_data", bus.write_data,         m_wdata);
    chk("m_pending",    {8'd0, bus.pending},    {8'd0, ep});
    chk("m_idle",       {15'd0, bus.idle},      {15'd0, (q.size() == 0 && !m_we)});
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  cid [4];
    logic [15:0] cdat [4];
    cid  = '{3'd1, 3'd6, 3'd1, 3'd6};
    cdat = '{16'hE001, 16'hD006, 16'hE001, 16'hD006};

    reset = 1'b0;
    bus.eu_valid = 1'b0; bus.eu_dual = 1'b0;
    bus.eu_id0 = 3'd0; bus.eu_id1 = 3'd0; bus.eu_data0 = 16'h0000; bus.eu_data1 = 16'h0000;
    bus.mem_valid = 1'b0; bus.mem_id = 3'd0; bus.mem_data = 16'h0000;
    cycle(); cycle();
    chk("rst_we",      {15'd0, bus.we},   16'd0);
    chk("rst_pending", {8'd0, bus.pending}, 16'd0);
    chk("rst_idle",    {15'd0, bus.idle}, 16'd1);
    chk("rst_eu_rdy",  {15'd0, bus.eu_ready}, 16'd0);
    reset = 1'b1;

    // MEM-only single write
    bus.mem_valid = 1'b1; bus.mem_id = 3'd3; bus.mem_data = 16'hBEEF;
    cycle();
    bus.mem_valid = 1'b0;
    chk("mem_we",      {15'd0, bus.we},       16'd1);
    chk("mem_id",      {13'd0, bus.write_id}, 16'd3);
    chk("mem_data",    bus.write_data,        16'hBEEF);
    chk("mem_pending", {8'd0, bus.pending},   16'h0008);
    cycle();
    chk("mem_we_off",  {15'd0, bus.we},       16'd0);
    chk("mem_pend_off",{8'd0, bus.pending},   16'h0000);
    chk("mem_idle",    {15'd0, bus.idle},     16'd1);

    // Contention, EU has priority first
    bus.eu_valid = 1'b1; bus.eu_dual = 1'b0; bus.eu_id0 = 3'd1; bus.eu_data0 = 16'hE001;
    bus.mem_valid = 1'b1; bus.mem_id = 3'd6; bus.mem_data = 16'hD006;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 3) begin bus.eu_valid = 1'b0; bus.mem_valid = 1'b0; end
      chk("cont_we",   {15'd0, bus.we},       16'd1);
      chk("cont_id",   {13'd0, bus.write_id}, {13'd0, cid[i]});
      chk("cont_data", bus.write_data,        cdat[i]);
    end
    cycle();

    // EU dual write
    bus.eu_valid = 1'b1; bus.eu_dual = 1'b1;
    bus.eu_id0 = 3'd0; bus.eu_data0 = 16'h1234; bus.eu_id1 = 3'd2; bus.eu_data1 = 16'h5678;
    bus.mem_valid = 1'b1; bus.mem_id = 3'd7; bus.mem_data = 16'h0777;
    cycle();
    bus.eu_valid = 1'b0;
    chk("dual_id0",    {13'd0, bus.write_id}, 16'd0);
    chk("dual_pend0",  {8'd0, bus.pending},   16'h0005);
    chk("dual_eu_rdy", {15'd0, bus.eu_ready}, 16'd0);
    chk("dual_mem_rdy",{15'd0, bus.mem_ready},16'd0);
    cycle();
    chk("dual_id1",    {13'd0, bus.write_id}, 16'd2);
    chk("dual_data1",  bus.write_data,        16'h5678);
    chk("dual_pend1",  {8'd0, bus.pending},   16'h0004);
    cycle();
    bus.mem_valid = 1'b0;
    chk("dual_then_mem", {13'd0, bus.write_id}, 16'd7);
    cycle(); cycle();

    // Same-register dual
    bus.eu_valid = 1'b1; bus.eu_dual = 1'b1;
    bus.eu_id0 = 3'd5; bus.eu_data0 = 16'hAAAA; bus.eu_id1 = 3'd5; bus.eu_data1 = 16'h5555;
    cycle();
    bus.eu_valid = 1'b0;
    chk("same_pend", {8'd0, bus.pending}, 16'h0020);
    cycle(); cycle();
    chk("same_rf5", rf[5], 16'h5555);

    // Reset during the second half
    bus.eu_valid = 1'b1; bus.eu_dual = 1'b1;
    bus.eu_id0 = 3'd3; bus.eu_data0 = 16'hC0DE; bus.eu_id1 = 3'd4; bus.eu_data1 = 16'hDEAD;
    cycle();
    bus.eu_valid = 1'b0;
    reset = 1'b0;
    cycle();
    chk("mid_we",   {15'd0, bus.we},     16'd0);
    chk("mid_pend", {8'd0, bus.pending}, 16'h0000);
    chk("mid_idle", {15'd0, bus.idle},   16'd1);
    reset = 1'b1;
    cycle();
    chk("mid_rf4",  rf[4], 16'h0000);
    chk("mid_rf3",  rf[3], 16'hC0DE);

    // Back-to-back EU singles
    bus.eu_dual = 1'b0; bus.eu_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.eu_id0 = 3'(i); bus.eu_data0 = 16'h7000 + 16'(i);
      cycle();
      chk("b2b_we",  {15'd0, bus.we},       16'd1);
      chk("b2b_id",  {13'd0, bus.write_id}, 16'(i));
      chk("b2b_rdy", {15'd0, bus.eu_ready}, 16'd1);
    end
    bus.eu_valid = 1'b0;
    cycle(); cycle();
    for (int i = 0; i < 8; i++) chk("b2b_rf", rf[i], 16'h7000 + 16'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
